// File: rtl/gb_memmap_pkg.sv
// Shared address map, boot-state and decode-region types for the CGB memory map.
// GB_MEMMAP_CGB_EN adds the VBK/SVBK register addresses and the upper boot ROM window.
package gb_memmap_pkg;

  localparam logic [15:0] ADR_VBK      = 16'hFF4F;
  localparam logic [15:0] ADR_BOOT     = 16'hFF50;
  localparam logic [15:0] ADR_SVBK     = 16'hFF70;

  localparam logic [15:0] BOOT_LO_END  = 16'h00FF;
  localparam logic [15:0] BOOT_HI_BASE = 16'h0200;
  localparam logic [15:0] BOOT_HI_END  = 16'h08FF;
  localparam logic [15:0] CART_END     = 16'h7FFF;
  localparam logic [15:0] VRAM_BASE    = 16'h8000;
  localparam logic [15:0] VRAM_END     = 16'h9FFF;
  localparam logic [15:0] XRAM_BASE    = 16'hA000;
  localparam logic [15:0] XRAM_END     = 16'hBFFF;
  localparam logic [15:0] WRAM_BASE    = 16'hC000;
  localparam logic [15:0] WRAM_END     = 16'hFDFF;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] OAM_END      = 16'hFEFF;
  localparam logic [15:0] IO_BASE      = 16'hFF00;

  typedef enum logic {
    BOOT,
    LOCKED
  } boot_state_e;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_REGS,
    RGN_BOOTROM,
    RGN_CART,
    RGN_VRAM,
    RGN_OAM,
    RGN_IO,
    RGN_RAM
  } region_e;

  function automatic logic is_reg_adr(input logic [15:0] a);
`ifdef GB_MEMMAP_CGB_EN
    return (a == ADR_VBK) || (a == ADR_BOOT) || (a == ADR_SVBK);
`else
    return a == ADR_BOOT;
`endif
  endfunction

  function automatic logic in_bootrom(input logic [15:0] a);
`ifdef GB_MEMMAP_CGB_EN
    return (a <= BOOT_LO_END) || ((a >= BOOT_HI_BASE) && (a <= BOOT_HI_END));
`else
    return a <= BOOT_LO_END;
`endif
  endfunction

endpackage

// File: rtl/gb_bankreg.sv
// Write-enabled W-bit bank register with optional 0->1 remap and padded 8-bit readback.
// Write visible the cycle after the strobe; synchronous active-high reset to 0 wins over we.
module gb_bankreg
  import gb_memmap_pkg::*;
#(
  parameter int         W          = 1,
  parameter bit         REMAP_ZERO = 1'b0,
  parameter logic [7:0] PAD        = 8'hFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] din,
  output logic [W-1:0] bank,
  output logic [7:0]   rdata
);

  logic [W-1:0] val_d;
  logic [W-1:0] val_q;

  always_comb begin
    val_d = val_q;
    if (reset) begin
      val_d = '0;
    end else if (we) begin
      val_d = din;
    end
  end

  always_ff @(posedge clk) begin
    val_q <= val_d;
  end

  // Readback shows the raw stored value; only the effective bank is remapped.
  assign bank  = (REMAP_ZERO && (val_q == '0)) ? W'(1) : val_q;
  assign rdata = {PAD[7:W], val_q};

endmodule

// File: rtl/gb_memmap_cgb.sv
// CPU address decoder, boot-ROM lock FSM and VBK/SVBK banking; CGB features under GB_MEMMAP_CGB_EN.
// Selects/addresses/readback are combinational (zero latency); register writes land next cycle.
module gb_memmap_cgb
  import gb_memmap_pkg::*;
#(
  parameter int VRAM_BANKS = 2,
  parameter int WRAM_BANKS = 8,
`ifdef GB_MEMMAP_CGB_EN
  localparam int VBK_W  = $clog2(VRAM_BANKS),
  localparam int SVBK_W = $clog2(WRAM_BANKS)
`else
  // DMG build: bank counts have no effect, widths collapse to one VRAM and two WRAM banks.
  localparam int VBK_W  = 0 * VRAM_BANKS,
  localparam int SVBK_W = 1 + 0 * WRAM_BANKS
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        adr,
  input  logic               wr,
  input  logic [7:0]         din,
  input  logic               dma_active,
  output logic               sel_bootrom,
  output logic               sel_cartridge,
  output logic               sel_vram,
  output logic               sel_ram,
  output logic               sel_oam,
  output logic               sel_io,
  output logic               sel_regs,
  output logic [7:0]         reg_dout,
  output logic [11:0]        bootrom_adr,
  output logic [12+VBK_W:0]  vram_adr,
  output logic [11+SVBK_W:0] ram_adr,
  output logic               boot_locked
);

  boot_state_e       state_q;
  logic              boot_locked_q;
  logic              boot_wr;
  region_e           rgn;
  logic              mem_ok;
  logic [SVBK_W-1:0] wram_bank;

  assign boot_wr = wr && (adr == ADR_BOOT) && (din != 8'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      boot_locked_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          if (boot_wr) begin
            state_q       <= LOCKED;
            boot_locked_q <= 1'b1;
          end
        end
        LOCKED: state_q <= LOCKED;
      endcase
    end
  end

  assign boot_locked = boot_locked_q;

  always_comb begin
    rgn = RGN_NONE;
    if (is_reg_adr(adr)) begin
      rgn = RGN_REGS;
    end else if ((state_q == BOOT) && in_bootrom(adr)) begin
      rgn = RGN_BOOTROM;
    end else if ((adr <= CART_END) || ((adr >= XRAM_BASE) && (adr <= XRAM_END))) begin
      rgn = RGN_CART;
    end else if ((adr >= VRAM_BASE) && (adr <= VRAM_END)) begin
      rgn = RGN_VRAM;
    end else if ((adr >= OAM_BASE) && (adr <= OAM_END)) begin
      rgn = RGN_OAM;
    end else if (adr >= IO_BASE) begin
      rgn = RGN_IO;
    end else if ((adr >= WRAM_BASE) && (adr <= WRAM_END)) begin
      rgn = RGN_RAM;
    end
  end

  // DMA only steals the external bus; IO and the internal registers stay reachable.
  assign mem_ok        = !reset && !dma_active;
  assign sel_regs      = !reset && (rgn == RGN_REGS);
  assign sel_io        = !reset && (rgn == RGN_IO);
  assign sel_bootrom   = mem_ok && (rgn == RGN_BOOTROM);
  assign sel_cartridge = mem_ok && (rgn == RGN_CART);
  assign sel_vram      = mem_ok && (rgn == RGN_VRAM);
  assign sel_oam       = mem_ok && (rgn == RGN_OAM);
  assign sel_ram       = mem_ok && (rgn == RGN_RAM);

`ifdef GB_MEMMAP_CGB_EN
  logic [7:0] vbk_rd;
  logic [7:0] svbk_rd;

  if (VBK_W > 0) begin : g_vbk
    logic [VBK_W-1:0] vbk;

    gb_bankreg #(
      .W          (VBK_W),
      .REMAP_ZERO (1'b0),
      .PAD        (8'hFF)
    ) u_vbk (
      .clk   (clk),
      .reset (reset),
      .we    (wr && (adr == ADR_VBK)),
      .din   (din[VBK_W-1:0]),
      .bank  (vbk),
      .rdata (vbk_rd)
    );

    assign vram_adr = {vbk, adr[12:0]};
  end else begin : g_no_vbk
    assign vram_adr = adr[12:0];
    assign vbk_rd   = 8'hFF;
  end

  gb_bankreg #(
    .W          (SVBK_W),
    .REMAP_ZERO (1'b1),
    .PAD        (8'hF8)
  ) u_svbk (
    .clk   (clk),
    .reset (reset),
    .we    (wr && (adr == ADR_SVBK)),
    .din   (din[SVBK_W-1:0]),
    .bank  (wram_bank),
    .rdata (svbk_rd)
  );

  always_comb begin
    reg_dout = 8'hFF;
    if (sel_regs) begin
      if (adr == ADR_VBK) begin
        reg_dout = vbk_rd;
      end else if (adr == ADR_SVBK) begin
        reg_dout = svbk_rd;
      end
    end
  end
`else
  assign vram_adr  = adr[12:0];
  assign wram_bank = 1'b1;
  assign reg_dout  = 8'hFF;
`endif

  assign bootrom_adr = adr[11:0];
  // Lower 4 KiB of the WRAM window (and its echo) is always bank 0.
  assign ram_adr     = {wram_bank & {SVBK_W{adr[12]}}, adr[11:0]};

endmodule

// File: tb/tb_gb_memmap_cgb.sv
// Self-checking bench for gb_memmap_cgb: directed scenarios plus randomized traffic
// compared against an address-map reference model; adapts to GB_MEMMAP_CGB_EN.
`timescale 1ns/1ps
module tb_gb_memmap_cgb;

  localparam int VB = 2;
  localparam int WB = 8;
`ifdef GB_MEMMAP_CGB_EN
  localparam bit CGB = 1'b1;
  localparam int VW  = 13 + $clog2(VB);
  localparam int RW  = 12 + $clog2(WB);
`else
  localparam bit CGB = 1'b0;
  localparam int VW  = 13;
  localparam int RW  = 13;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   adr;
  logic          wr;
  logic [7:0]    din;
  logic          dma_active;
  logic          sel_bootrom, sel_cartridge, sel_vram, sel_ram, sel_oam, sel_io, sel_regs;
  logic [7:0]    reg_dout;
  logic [11:0]   bootrom_adr;
  logic [VW-1:0] vram_adr;
  logic [RW-1:0] ram_adr;
  logic          boot_locked;

  gb_memmap_cgb #(.VRAM_BANKS(VB), .WRAM_BANKS(WB)) dut (
    .clk           (clk),
    .reset         (reset),
    .adr           (adr),
    .wr            (wr),
    .din           (din),
    .dma_active    (dma_active),
    .sel_bootrom   (sel_bootrom),
    .sel_cartridge (sel_cartridge),
    .sel_vram      (sel_vram),
    .sel_ram       (sel_ram),
    .sel_oam       (sel_oam),
    .sel_io        (sel_io),
    .sel_regs      (sel_regs),
    .reg_dout      (reg_dout),
    .bootrom_adr   (bootrom_adr),
    .vram_adr      (vram_adr),
    .ram_adr       (ram_adr),
    .boot_locked   (boot_locked)
  );

  always #5 clk = ~clk;

  // sel bits: [6] bootrom [5] cart [4] vram [3] ram [2] oam [1] io [0] regs
  typedef struct packed {
    logic [6:0]    sel;
    logic [7:0]    dout;
    logic [11:0]   boot;
    logic [VW-1:0] vram;
    logic [RW-1:0] ram;
    logic          locked;
  } obs_t;

  obs_t act;
  obs_t exp_o;
  assign act = {sel_bootrom, sel_cartridge, sel_vram, sel_ram, sel_oam, sel_io, sel_regs,
                reg_dout, bootrom_adr, vram_adr, ram_adr, boot_locked};

  int asserts  = 0;
  int failures = 0;

  bit m_locked;
  int m_vbk;
  int m_svbk;

  function automatic obs_t model_out(input logic [15:0] a, input logic dma, input logic rst);
    obs_t o;
    int   ia;
    int   eff;
    bit   is_reg;
    ia     = int'(a);
    is_reg = (ia == 'hFF50) || (CGB && ((ia == 'hFF4F) || (ia == 'hFF70)));
    o.sel  = '0;
    if (is_reg) o.sel[0] = 1'b1;
    else if (!m_locked && ((ia <= 'hFF) || (CGB && ia >= 'h200 && ia <= 'h8FF))) o.sel[6] = 1'b1;
    else if ((ia < 'h8000) || (ia >= 'hA000 && ia < 'hC000)) o.sel[5] = 1'b1;
    else if (ia < 'hA000) o.sel[4] = 1'b1;
    else if (ia < 'hFE00) o.sel[3] = 1'b1;
    else if (ia < 'hFF00) o.sel[2] = 1'b1;
    else o.sel[1] = 1'b1;
    if (dma) o.sel[6:2] = '0;
    if (rst) o.sel = '0;
    o.dout = 8'hFF;
    if (o.sel[0] && CGB) begin
      if (ia == 'hFF4F) o.dout = 8'(255 - (VB - 1) + m_vbk);
      else if (ia == 'hFF70) o.dout = 8'('hF8 + m_svbk);
    end
    o.boot   = 12'(ia % 4096);
    o.vram   = VW'(m_vbk * 8192 + ia % 8192);
    eff      = (m_svbk == 0) ? 1 : m_svbk;
    o.ram    = RW'((((ia % 8192) < 4096) ? 0 : eff) * 4096 + ia % 4096);
    o.locked = m_locked;
    return o;
  endfunction

  function automatic void model_clock();
    if (reset) begin
      m_locked = 1'b0;
      m_vbk    = 0;
      m_svbk   = 0;
    end else if (wr) begin
      if (adr == 16'hFF50 && din != 8'h00) m_locked = 1'b1;
      if (CGB && adr == 16'hFF4F) m_vbk = int'(din) % VB;
      if (CGB && adr == 16'hFF70) m_svbk = (int'(din) % 8) % WB;
    end
  endfunction

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d,
                       input logic dm, input logic rst);
    adr = a; wr = w; din = d; dma_active = dm; reset = rst;
    #1;
  endtask

  task automatic test_reset();
    drive(16'h0050, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    tick();
    asserts++;
    if (act.sel !== 7'b0 || reg_dout !== 8'hFF || boot_locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs sel=%b dout=%h locked=%b need sel=0 dout=ff locked=0",
               act.sel, reg_dout, boot_locked);
    end
    drive(16'hFF70, 1'b0, 8'h00, 1'b0, 1'b1);
    exp_o = model_out(adr, dma_active, reset);
    asserts++;
    if (act !== exp_o) begin
      failures++;
      $display("FAIL reset_regread got=%h need=%h", act, exp_o);
    end
    drive(16'h0050, 1'b0, 8'h00, 1'b0, 1'b0);
    asserts++;
    if (sel_bootrom !== 1'b1 || boot_locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_boot sel_bootrom=%b locked=%b need 1/0", sel_bootrom, boot_locked);
    end
  endtask

  task automatic test_boot_lock();
    drive(16'hFF50, 1'b1, 8'h01, 1'b0, 1'b0);
    asserts++;
    if (sel_regs !== 1'b1 || boot_locked !== 1'b0 || reg_dout !== 8'hFF) begin
      failures++;
      $display("FAIL lock_write_cycle regs=%b locked=%b dout=%h need 1/0/ff",
               sel_regs, boot_locked, reg_dout);
    end
    tick();
    drive(16'h0050, 1'b0, 8'h00, 1'b0, 1'b0);
    asserts++;
    if (sel_cartridge !== 1'b1 || sel_bootrom !== 1'b0 || boot_locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_after cart=%b boot=%b locked=%b need 1/0/1",
               sel_cartridge, sel_bootrom, boot_locked);
    end
  endtask

  task automatic test_lock_sticky();
    drive(16'hFF50, 1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    drive(16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
    asserts++;
    if (boot_locked !== 1'b1 || sel_cartridge !== 1'b1) begin
      failures++;
      $display("FAIL lock_sticky locked=%b cart=%b need 1/1", boot_locked, sel_cartridge);
    end
    drive(16'h0000, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    drive(16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
    asserts++;
    if (boot_locked !== 1'b0 || sel_bootrom !== 1'b1) begin
      failures++;
      $display("FAIL unlock_by_reset locked=%b boot=%b need 0/1", boot_locked, sel_bootrom);
    end
    drive(16'hFF50, 1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    drive(16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
    asserts++;
    if (boot_locked !== 1'b0 || sel_bootrom !== 1'b1) begin
      failures++;
      $display("FAIL zero_write_no_lock locked=%b boot=%b need 0/1", boot_locked, sel_bootrom);
    end
  endtask

  task automatic test_svbk();
    int sv[3]   = '{'h00, 'h03, 'h07};
    int ramd[3] = '{'h1123, 'h3123, 'h7123};
    int rdv[3]  = '{'hF8, 'hFB, 'hFF};
    int need_d;
    for (int i = 0; i < 3; i++) begin
      drive(16'hFF70, 1'b1, 8'(sv[i]), 1'b0, 1'b0);
      tick();
      need_d = CGB ? ramd[i] : 'h1123;
      drive(16'hD123, 1'b0, 8'h00, 1'b0, 1'b0);
      asserts++;
      if (ram_adr !== RW'(need_d) || sel_ram !== 1'b1) begin
        failures++;
        $display("FAIL svbk_d123[%0d] ram_adr=%h sel_ram=%b need %h/1", i, ram_adr, sel_ram, need_d);
      end
      drive(16'hC123, 1'b0, 8'h00, 1'b0, 1'b0);
      asserts++;
      if (ram_adr !== RW'('h0123)) begin
        failures++;
        $display("FAIL svbk_c123[%0d] ram_adr=%h need 0123", i, ram_adr);
      end
      drive(16'hF123, 1'b0, 8'h00, 1'b0, 1'b0);
      asserts++;
      if (ram_adr !== RW'(need_d) || sel_ram !== 1'b1) begin
        failures++;
        $display("FAIL svbk_echo[%0d] ram_adr=%h sel_ram=%b need %h/1", i, ram_adr, sel_ram, need_d);
      end
      drive(16'hFF70, 1'b0, 8'h00, 1'b0, 1'b0);
      asserts++;
      if (reg_dout !== 8'(CGB ? rdv[i] : 'hFF)) begin
        failures++;
        $display("FAIL svbk_read[%0d] reg_dout=%h need %h", i, reg_dout, CGB ? rdv[i] : 'hFF);
      end
    end
  endtask

  task automatic test_vbk();
    drive(16'hFF4F, 1'b1, 8'h01, 1'b0, 1'b0);
    asserts++;
    if (reg_dout !== 8'(CGB ? 'hFE : 'hFF)) begin
      failures++;
      $display("FAIL vbk_same_cycle reg_dout=%h need old value %h", reg_dout, CGB ? 'hFE : 'hFF);
    end
    tick();
    drive(16'h8010, 1'b0, 8'h00, 1'b0, 1'b0);
    asserts++;
    if (vram_adr !== VW'(CGB ? 'h2010 : 'h0010) || sel_vram !== 1'b1) begin
      failures++;
      $display("FAIL vbk1_vram vram_adr=%h sel_vram=%b need %h/1", vram_adr, sel_vram,
               CGB ? 'h2010 : 'h0010);
    end
    drive(16'hFF4F, 1'b0, 8'h00, 1'b0, 1'b0);
    asserts++;
    if (reg_dout !== 8'hFF) begin
      failures++;
      $display("FAIL vbk1_read reg_dout=%h need ff", reg_dout);
    end
    drive(16'hFF4F, 1'b1, 8'hFE, 1'b0, 1'b0);
    tick();
    drive(16'h8010, 1'b0, 8'h00, 1'b0, 1'b0);
    asserts++;
    if (vram_adr !== VW'('h0010)) begin
      failures++;
      $display("FAIL vbk0_vram vram_adr=%h need 0010", vram_adr);
    end
    drive(16'hFF4F, 1'b0, 8'h00, 1'b0, 1'b0);
    asserts++;
    if (reg_dout !== 8'(CGB ? 'hFE : 'hFF)) begin
      failures++;
      $display("FAIL vbk0_read reg_dout=%h need %h", reg_dout, CGB ? 'hFE : 'hFF);
    end
  endtask

  task automatic test_dma_sweep();
    int bad;
    drive(16'h0000, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    bad = 0;
    for (int a = 0; a < 65536; a++) begin
      drive(16'(a), 1'b0, 8'h00, 1'b1, 1'b0);
      exp_o = model_out(adr, 1'b1, 1'b0);
      if ((act.sel[6:2] !== 5'b0) || (act.sel[1:0] !== exp_o.sel[1:0])) begin
        if (bad < 4) $display("FAIL dma_sweep adr=%h sel=%b need %b", adr, act.sel, exp_o.sel);
        bad++;
      end
    end
    asserts++;
    if (bad != 0) begin
      failures++;
      $display("FAIL dma_sweep_total bad_addresses=%0d need 0", bad);
    end
    drive(16'hFF70, 1'b1, 8'h05, 1'b1, 1'b0);
    tick();
    drive(16'hFF50, 1'b1, 8'h01, 1'b1, 1'b0);
    tick();
    drive(16'hFF70, 1'b0, 8'h00, 1'b1, 1'b0);
    asserts++;
    if (reg_dout !== 8'(CGB ? 'hFD : 'hFF) || boot_locked !== 1'b1) begin
      failures++;
      $display("FAIL dma_reg_write reg_dout=%h locked=%b need %h/1", reg_dout, boot_locked,
               CGB ? 'hFD : 'hFF);
    end
  endtask

  task automatic test_reset_wr();
    drive(16'hFF4F, 1'b1, 8'h00, 1'b0, 1'b1);
    tick();
    drive(16'hFF4F, 1'b1, 8'h01, 1'b0, 1'b1);
    asserts++;
    if (act.sel !== 7'b0 || reg_dout !== 8'hFF) begin
      failures++;
      $display("FAIL reset_wr_sel sel=%b dout=%h need 0/ff", act.sel, reg_dout);
    end
    tick();
    drive(16'h8010, 1'b0, 8'h00, 1'b0, 1'b0);
    asserts++;
    if (vram_adr !== VW'('h0010)) begin
      failures++;
      $display("FAIL reset_wr_vbk vram_adr=%h need 0010", vram_adr);
    end
  endtask

  task automatic test_random();
    logic [15:0] regs[3] = '{16'hFF4F, 16'hFF50, 16'hFF70};
    logic [15:0] a;
    logic [7:0]  d;
    for (int n = 0; n < 1500; n++) begin
      a = ($urandom_range(0, 3) == 0) ? regs[$urandom_range(0, 2)] : 16'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      drive(a, ($urandom_range(0, 2) == 0), d, ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 39) == 0));
      exp_o = model_out(adr, dma_active, reset);
      asserts++;
      if (act !== exp_o) begin
        failures++;
        $display("FAIL random[%0d] adr=%h got=%h need=%h", n, adr, act, exp_o);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; adr = 16'h0; wr = 1'b0; din = 8'h0; dma_active = 1'b0;
    m_locked = 1'b0; m_vbk = 0; m_svbk = 0;
    test_reset();
    test_boot_lock();
    test_lock_sticky();
    test_svbk();
    test_vbk();
    test_dma_sweep();
    test_reset_wr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/gb_memmap_cgb.md
# gb_memmap_cgb

Parametrised successor of the system address decoder. It decodes the 16-bit CPU address into region selects and owns the boot-ROM lock state machine. It also owns the CGB bank registers VBK (0xFF4F) and SVBK (0xFF70), and produces banked physical addresses for VRAM, work RAM and boot ROM. It sits between the CPU bus and the memory/peripheral blocks, and gates CPU access while OAM DMA owns the bus.

## Interface
Parameters:
- VRAM_BANKS, 2: number of 8 KiB VRAM banks; power of two, 1..2.
- WRAM_BANKS, 8: number of 4 KiB WRAM banks; power of two, 2..8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- adr  in  16  CPU address.
- wr  in  1  one-cycle write strobe, qualified by adr/din.
- din  in  8  CPU write data.
- dma_active  in  1  OAM DMA owns the external bus.
- sel_bootrom, sel_cartridge, sel_vram, sel_ram, sel_oam, sel_io, sel_regs  out  1 each  region selects; one-hot or all zero.
- reg_dout  out  8  readback of the internal registers.
- bootrom_adr  out  12  boot ROM byte address.
- vram_adr  out  13+clog2(VRAM_BANKS)  banked VRAM address.
- ram_adr  out  12+clog2(WRAM_BANKS)  banked WRAM address.
- boot_locked  out  1  boot ROM permanently hidden.

## Operation
- Boot-ROM state machine, two states:
  - BOOT (reset state) moves to LOCKED on wr with adr==0xFF50 and din!=0.
  - LOCKED is sticky; only reset leaves it. Writes to 0xFF50 in LOCKED are ignored.
  - boot_locked = (state==LOCKED).
- Decode priority, highest first:
  - sel_regs: internal register addresses.
  - sel_bootrom: in BOOT state only, for 0x0000-0x00FF; with the CGB feature also for 0x0200-0x08FF.
  - sel_cartridge: 0x0000-0x7FFF and 0xA000-0xBFFF.
  - sel_vram: 0x8000-0x9FFF.
  - sel_oam: 0xFE00-0xFEFF.
  - sel_io: 0xFF00-0xFFFF, excluding register addresses.
  - sel_ram: 0xC000-0xFDFF, with echo.
- dma_active=1 forces sel_bootrom, sel_cartridge, sel_vram, sel_ram and sel_oam to 0. sel_io and sel_regs are unaffected, and register writes are still accepted.
- reset=1 forces every select to 0.
- VBK: low clog2(VRAM_BANKS) bits of din are stored on write. Read value = 0xFF with the bank bits replaced by the bank.
- SVBK: din[2:0] is stored raw, masked to clog2(WRAM_BANKS) bits. Read value = 0xF8 | stored value.
  - Effective bank = stored value, except that stored 0 maps to bank 1.
- 0xFF50 reads 0xFF.
- reg_dout = 0xFF when sel_regs=0.
- Address outputs:
  - vram_adr = {vbk, adr[12:0]}.
  - bootrom_adr = adr[11:0].
  - ram_adr = {bank, adr[11:0]}, where bank = 0 for offset 0x0000-0x0FFF within the 8 KiB window (adr[12]=0), else the effective SVBK bank. The echo region uses the same mapping.
- Reset values:
  - state BOOT, vbk 0, svbk 0 (effective 1).
  - All selects 0, boot_locked 0, reg_dout 0xFF.
  - Address outputs follow adr.

## Timing
- All selects, address outputs and reg_dout are combinational from adr and the current state; zero latency.
- A register write on edge N is visible in outputs from cycle N+1.
  - A read of the same register in the cycle of its write returns the old value.
- reset and wr in the same cycle: reset wins and the write is lost.
- Reset asserted mid-boot or after lock returns the block to BOOT with banks 0.
- dma_active toggling mid-access takes effect combinationally in the same cycle.

## Configuration
- GB_MEMMAP_CGB_EN defined:
  - VBK and SVBK exist.
  - The boot ROM also covers 0x0200-0x08FF.
  - sel_regs covers 0xFF4F, 0xFF50 and 0xFF70.
- GB_MEMMAP_CGB_EN undefined:
  - DMG behaviour: vbk is fixed 0 and the effective WRAM bank is fixed 1.
  - 0xFF4F and 0xFF70 decode to sel_io.
  - The boot ROM is 0x0000-0x00FF only.
  - sel_regs covers 0xFF50 only.
  - Parameters are ignored, with widths at their minimum (VRAM_BANKS=1, WRAM_BANKS=2).

## Structure
- Package gb_memmap_pkg holds:
  - address constants: region bases/limits, ADR_VBK, ADR_BOOT, ADR_SVBK;
  - the boot-state enum type (BOOT, LOCKED);
  - the region enum used by the decode.
- One sub-module, gb_bankreg: a parametrised-width write-enabled bank register with optional zero-to-one remap and readback padding. It is instantiated for VBK and SVBK.

## Test plan
- Reset, then read adr=0x0050 -> sel_bootrom=1, boot_locked=0. Write 0xFF50 with din=0x01 -> next cycle sel_cartridge=1 at 0x0050, boot_locked=1.
- In LOCKED, write 0xFF50 with din=0x00, then reset -> stays LOCKED until reset, then returns to BOOT with sel_bootrom=1 at 0x0000.
- Write SVBK with 0x00, 0x03, 0x07 -> ram_adr at 0xD123 = 0x1123, 0x3123, 0x7123. Also:
  - at 0xC123 -> 0x0123;
  - at echo 0xF123 -> matches 0xD123;
  - SVBK readback = 0xF8, 0xFB, 0xFF.
- Write VBK with 0x01 -> vram_adr at 0x8010 = 0x2010 and reg_dout = 0xFF. Write 0xFE -> bank 0, reg_dout = 0xFE.
- With dma_active=1, sweep adr over 0x0000-0xFFFF -> only sel_io/sel_regs ever assert, and a write to 0xFF70 is still accepted.
- Assert reset and wr to 0xFF4F in the same cycle -> vbk stays 0 and all selects are 0 while reset is high.
